// File: rtl/regwrite_pkg.sv
// regwrite_pkg: shared types and constants for the register-write scheduler.
//   BYTES_PER_WORD : UART bytes assembled into one 32-bit input word
//   CNT_W          : byte-counter width
//   state_t        : scheduler FSM state encoding
package regwrite_pkg;
    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        PEND = 2'd2
    } state_t;
endpackage

// File: rtl/regwrite_sched_if.sv
// regwrite_sched_if: bundle of core writeback, input-instruction, UART receive
// and register-file write signals.
//   master : drives wb_*, in_*, rx_valid/rx_data; observes the rest
//   slave  : the scheduler side
interface regwrite_sched_if #(
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      wb_req;
    logic [REG_ADDR_WIDTH-1:0] wb_addr;
    logic [31:0]               wb_data;
    logic                      in_req;
    logic [REG_ADDR_WIDTH-1:0] in_addr;
    logic                      rx_valid;
    logic [7:0]                rx_data;
    logic                      rx_ready;
    logic                      rf_we;
    logic [REG_ADDR_WIDTH-1:0] rf_addr;
    logic [31:0]               rf_wdata;
    logic                      pc_enable;
    logic                      in_done;

    modport master (
        output wb_req, wb_addr, wb_data, in_req, in_addr, rx_valid, rx_data,
        input  rx_ready, rf_we, rf_addr, rf_wdata, pc_enable, in_done
    );
    modport slave (
        input  wb_req, wb_addr, wb_data, in_req, in_addr, rx_valid, rx_data,
        output rx_ready, rf_we, rf_addr, rf_wdata, pc_enable, in_done
    );
endinterface

// File: rtl/uart_word_assembler.sv
// uart_word_assembler: shifts UART bytes MSB-first into a word and counts them.
//   CLK, reset : clock, async active-low reset
//   i_clear    : zero counter and word buffer
//   i_load     : accept i_data this cycle
//   o_word     : assembled word (first byte ends up in the top byte)
//   o_full     : this load is the last byte of the word
module uart_word_assembler #(
    parameter int BYTES = 4
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               i_clear,
    input  logic               i_load,
    input  logic [7:0]         i_data,
    output logic [8*BYTES-1:0] o_word,
    output logic               o_full
);
    import regwrite_pkg::*;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

    logic [CNT_W-1:0]   r_cnt;
    logic [8*BYTES-1:0] r_word;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_clear) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_load) begin
            r_word <= {r_word[8*BYTES-9:0], i_data};
            // Saturate on the last byte so the count never wraps inside a word.
            if (r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_word = r_word;
    assign o_full = i_load && (r_cnt == LAST);
endmodule

// File: rtl/regwrite_sched.sv
// regwrite_sched: shares one register-file write port between core writeback
// and UART-sourced input words, stalling the PC while an input word is built.
//   CLK, reset : clock, async active-low reset
//   bus        : regwrite_sched_if slave (writeback, input request, UART rx,
//                register-file write, pc_enable, in_done)
module regwrite_sched #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int BYTES_PER_WORD = 4
) (
    input  logic            CLK,
    input  logic            reset,
    regwrite_sched_if.slave bus
);
    import regwrite_pkg::*;

    state_t                    r_state, w_next;
    logic                      r_in_prev;
    logic [REG_ADDR_WIDTH-1:0] r_addr;
    logic                      r_rf_we;
    logic [REG_ADDR_WIDTH-1:0] r_rf_addr;
    logic [31:0]               r_rf_wdata;
    logic                      r_in_done;
    logic                      r_pc_enable;

    logic        w_rise, w_accept, w_start, w_uart_grant, w_full;
    logic [31:0] w_word;

    assign w_rise   = bus.in_req && !r_in_prev;
    assign w_accept = (r_state == RECV) && bus.rx_valid;

    uart_word_assembler #(.BYTES(BYTES_PER_WORD)) u_asm (
        .CLK     (CLK),
        .reset   (reset),
        .i_clear (w_start),
        .i_load  (w_accept),
        .i_data  (bus.rx_data),
        .o_word  (w_word),
        .o_full  (w_full)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_start      = 1'b0;
        w_uart_grant = 1'b0;
        case (r_state)
            IDLE: if (w_rise) begin
                w_start = 1'b1;
                w_next  = RECV;
            end
            RECV: if (w_full) w_next = PEND;
            // Core writeback always wins; the UART word waits until a free cycle.
            PEND: if (!bus.wb_req) begin
                w_uart_grant = 1'b1;
                w_next       = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_in_prev   <= 1'b0;
            r_addr      <= '0;
            r_rf_we     <= 1'b0;
            r_rf_addr   <= '0;
            r_rf_wdata  <= '0;
            r_in_done   <= 1'b0;
            r_pc_enable <= 1'b1;
        end else begin
            r_in_prev <= bus.in_req;
            r_in_done <= w_uart_grant;
            if (w_start) r_addr <= bus.in_addr;
            if (w_start)           r_pc_enable <= 1'b0;
            else if (w_uart_grant) r_pc_enable <= 1'b1;
            // Writes to r0 are dropped, but done/pc recovery still happen.
            if (bus.wb_req) begin
                r_rf_we    <= |bus.wb_addr;
                r_rf_addr  <= bus.wb_addr;
                r_rf_wdata <= bus.wb_data;
            end else if (w_uart_grant) begin
                r_rf_we    <= |r_addr;
                r_rf_addr  <= r_addr;
                r_rf_wdata <= w_word;
            end else begin
                r_rf_we <= 1'b0;
            end
        end
    end

    assign bus.rx_ready  = (r_state == RECV);
    assign bus.rf_we     = r_rf_we;
    assign bus.rf_addr   = r_rf_addr;
    assign bus.rf_wdata  = r_rf_wdata;
    assign bus.in_done   = r_in_done;
    assign bus.pc_enable = r_pc_enable;
endmodule

// File: tb/tb_regwrite_sched.sv
module tb_regwrite_sched;
    logic CLK = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   n_done = 0;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        done;
    } exp_t;
    exp_t q[$];

    always #5 CLK = ~CLK;

    regwrite_sched_if #(.REG_ADDR_WIDTH(5)) bus ();

    regwrite_sched #(.REG_ADDR_WIDTH(5), .BYTES_PER_WORD(4)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every write or in_done pulse must match the oldest expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (reset === 1'b1 && (bus.rf_we === 1'b1 || bus.in_done === 1'b1)) begin
            if (bus.in_done === 1'b1) n_done++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_write: we=%0b addr=%0d data=%0h done=%0b expected none",
                       bus.rf_we, bus.rf_addr, bus.rf_wdata, bus.in_done);
            end else begin
                e = q.pop_front();
                chk("wr_we", 32'(bus.rf_we), 32'(e.we));
                chk("wr_done", 32'(bus.in_done), 32'(e.done));
                if (e.we) begin
                    chk("wr_addr", 32'(bus.rf_addr), 32'(e.addr));
                    chk("wr_data", bus.rf_wdata, e.data);
                end
            end
        end
    end

    task automatic xfer(input logic [4:0] a, input logic [31:0] d, input bit hold);
        bus.in_req  = 1'b1;
        bus.in_addr = a;
        step();
        chk("start_pc_en", 32'(bus.pc_enable), 0);
        chk("start_rx_ready", 32'(bus.rx_ready), 1);
        for (int i = 0; i < 4; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = d[31-8*i -: 8];
            step();
            chk("recv_pc_en", 32'(bus.pc_enable), 0);
        end
        bus.rx_valid = 1'b0;
        chk("pend_rx_ready", 32'(bus.rx_ready), 0);
        q.push_back('{we: (a != 5'd0), addr: a, data: d, done: 1'b1});
        step();
        chk("done_pc_en", 32'(bus.pc_enable), 1);
        if (!hold) bus.in_req = 1'b0;
        step();
    endtask

    initial begin
        int d0;
        reset        = 1'b0;
        bus.wb_req   = 1'b0;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;
        bus.in_req   = 1'b0;
        bus.in_addr  = '0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        repeat (2) step();
        chk("rst_rf_we", 32'(bus.rf_we), 0);
        chk("rst_rf_addr", 32'(bus.rf_addr), 0);
        chk("rst_rf_wdata", bus.rf_wdata, 0);
        chk("rst_rx_ready", 32'(bus.rx_ready), 0);
        chk("rst_in_done", 32'(bus.in_done), 0);
        chk("rst_pc_en", 32'(bus.pc_enable), 1);
        reset = 1'b1;
        step();

        // Plain core writeback.
        bus.wb_req = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h1234;
        q.push_back('{we: 1'b1, addr: 5'd3, data: 32'h1234, done: 1'b0});
        step();
        bus.wb_req = 1'b0;
        step();

        // Writeback to r0 is suppressed.
        bus.wb_req = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h55;
        step();
        bus.wb_req = 1'b0;
        step();

        // Basic UART word.
        xfer(5'd7, 32'hDEADBEEF, 1'b0);

        // Writeback held 3 cycles starting on the 4th byte.
        d0 = n_done;
        bus.in_req = 1'b1; bus.in_addr = 5'd12;
        step();
        for (int i = 0; i < 3; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'(i + 1);
            step();
        end
        bus.rx_data = 8'h04;
        bus.wb_req = 1'b1; bus.wb_addr = 5'd1; bus.wb_data = 32'hA0;
        q.push_back('{we: 1'b1, addr: 5'd1, data: 32'hA0, done: 1'b0});
        step();
        bus.rx_valid = 1'b0;
        bus.wb_addr = 5'd2; bus.wb_data = 32'hB0;
        q.push_back('{we: 1'b1, addr: 5'd2, data: 32'hB0, done: 1'b0});
        step();
        bus.wb_addr = 5'd3; bus.wb_data = 32'hC0;
        q.push_back('{we: 1'b1, addr: 5'd3, data: 32'hC0, done: 1'b0});
        step();
        bus.wb_req = 1'b0;
        chk("wbhold_pc_en", 32'(bus.pc_enable), 0);
        q.push_back('{we: 1'b1, addr: 5'd12, data: 32'h01020304, done: 1'b1});
        step();
        chk("wbhold_pc_en_back", 32'(bus.pc_enable), 1);
        bus.in_req = 1'b0;
        repeat (2) step();
        chk("wbhold_one_done", n_done - d0, 1);

        // Input word to r0: no write, but done and pc recovery.
        xfer(5'd0, 32'h13572468, 1'b0);

        // Reset after two bytes discards them.
        bus.in_req = 1'b1; bus.in_addr = 5'd9;
        step();
        bus.rx_valid = 1'b1; bus.rx_data = 8'h11;
        step();
        bus.rx_data = 8'h22;
        step();
        bus.rx_valid = 1'b0;
        bus.in_req   = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst_pc_en", 32'(bus.pc_enable), 1);
        chk("midrst_rx_ready", 32'(bus.rx_ready), 0);
        chk("midrst_rf_we", 32'(bus.rf_we), 0);
        step();
        reset = 1'b1;
        step();
        xfer(5'd9, 32'hCAFEF00D, 1'b0);

        // in_req held high after completion: no retrigger until it toggles.
        xfer(5'd5, 32'h0A0B0C0D, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'hFF;
            step();
            chk("hold_rx_ready", 32'(bus.rx_ready), 0);
            chk("hold_pc_en", 32'(bus.pc_enable), 1);
        end
        bus.rx_valid = 1'b0;
        bus.in_req   = 1'b0;
        step();
        xfer(5'd6, 32'h600D600D, 1'b0);

        repeat (3) step();
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regwrite_sched.md
REGWRITE_SCHED -- requirements
Module: regwrite_sched

Interface
REQ-001 SHALL have parameter REG_ADDR_WIDTH, default 5, register-file address width.
REQ-002 SHALL have parameter BYTES_PER_WORD, default 4, UART bytes assembled per input word; fixed at 4 for this revision.
REQ-003 CLK  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 wb_req  input  1  core writeback valid this cycle.
REQ-006 wb_addr  input  REG_ADDR_WIDTH  core writeback destination.
REQ-007 wb_data  input  32  core writeback value.
REQ-008 in_req  input  1  level; high while an input instruction awaits a UART word.
REQ-009 in_addr  input  REG_ADDR_WIDTH  destination of the input word; sampled on in_req rising edge.
REQ-010 rx_valid  input  1  UART receive byte valid.
REQ-011 rx_data  input  8  UART receive byte.
REQ-012 rx_ready  output  1  byte accepted when rx_valid && rx_ready.
REQ-013 rf_we  output  1  register-file write enable.
REQ-014 rf_addr  output  REG_ADDR_WIDTH  write address.
REQ-015 rf_wdata  output  32  write data.
REQ-016 pc_enable  output  1  low stalls program-counter advance.
REQ-017 in_done  output  1  one-cycle pulse coincident with the UART-word write.

Function
REQ-018 FSM states: IDLE, RECV, PEND; an illegal encoding SHALL return to IDLE.
REQ-019 IDLE: an in_req rising edge (in_req=1, previous sample 0) SHALL latch in_addr, clear the byte counter, enter RECV, and drive pc_enable=0 from the next cycle.
REQ-020 RECV: rx_ready=1; each accepted byte SHALL shift in MSB-first (first byte -> bits 31:24).
REQ-021 RECV: after the 4th accepted byte, the state SHALL be PEND on the next cycle; rx_ready=0 in IDLE and PEND.
REQ-022 Write-port arbitration each cycle: wb_req has strict priority; otherwise, in PEND, the assembled word is granted.
REQ-023 All rf_* outputs SHALL be registered: a grant in cycle t gives rf_we=1 in cycle t+1 with the matching addr/data; rf_we=0 when nothing is granted.
REQ-024 Core writeback SHALL be accepted in every state, including while pc_enable=0, so the pipeline drains.
REQ-025 UART grant SHALL produce, in the same output cycle, rf_we=1, in_done=1 and pc_enable=1, and the state SHALL return to IDLE.
REQ-026 Any write with rf_addr=0 SHALL be suppressed (rf_we=0); in_done and pc_enable recovery still occur.
REQ-027 in_req falling during RECV/PEND SHALL be ignored; the transfer completes.
REQ-028 A new in_req rising edge SHALL be recognised only in IDLE; edge memory SHALL update every cycle.
REQ-029 The byte counter SHALL be 2 bits and SHALL NOT wrap within a word; bytes are never accepted outside RECV.
REQ-030 A simultaneous wb_req and 4th byte SHALL grant wb, accept the byte, and delay the UART write by at least one cycle.

Reset
REQ-031 reset low SHALL force: state=IDLE, counter=0, word buffer=0, edge memory=0, rf_we=0, rf_addr=0, rf_wdata=0, rx_ready=0, in_done=0, pc_enable=1.
REQ-032 Reset mid-RECV/PEND SHALL discard partial bytes with no write.

Structure
REQ-033 Package regwrite_pkg SHALL hold the state enum, BYTES_PER_WORD and the byte-counter width.
REQ-034 Byte shifting and counting SHALL be a sub-module, uart_word_assembler (load/clear/count/full).

Verification
REQ-035 Scenario: wb_req=1, addr=3, data=0x1234 -> next cycle rf_we=1, rf_addr=3, rf_wdata=0x1234.
REQ-036 Scenario: in_req rise with addr=7, bytes 0xDE,0xAD,0xBE,0xEF -> pc_enable=0 throughout; one write of 0xDEADBEEF to r7 with in_done=1 and pc_enable=1.
REQ-037 Scenario: wb_req held 3 cycles starting at the 4th byte -> 3 wb writes first, then the UART write; exactly one in_done.
REQ-038 Scenario: in_req with in_addr=0 -> no rf_we; in_done pulses; pc_enable returns to 1.
REQ-039 Scenario: reset asserted after 2 bytes, then released -> pc_enable=1 and IDLE; a new 4-byte transfer writes only its own bytes.
REQ-040 Scenario: in_req held high after completion -> no second transfer until in_req falls and rises again.
